ahb_resp_mux: RTL
=================

Name: ahb_resp_mux

Overview:
Data-phase response multiplexer that sits directly downstream of the AHB address decoder.
- Registers the decoder's one-hot hsel on each accepted address phase.
- Routes the selected slave's hrdata/hresp/hreadyout back to the master as bus-level hrdata/hresp/hready.
- Contains the AHB default slave, which returns a two-cycle ERROR response for NONSEQ/SEQ transfers that hit no mapped region.
- Its hready output is the bus-wide ready, fed back to the master and to every slave's hreadyin.

Parameters:
slave_c, SLAVE_COUNT, number of slaves; width of hsel and of the per-slave response vectors.

Ports:
hclk  input  1  AHB clock; all state updates on rising edge.
hreset  input  1  synchronous, active-high reset.
hsel  input  slave_c  one-hot address-phase select from the decoder.
htrans  input  2  address-phase transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
hrdata_s  input  slave_c x 32  per-slave read data, packed array.
hresp_s  input  slave_c  per-slave response (0 OKAY, 1 ERROR).
hreadyout_s  input  slave_c  per-slave hreadyout.
hrdata  output  32  muxed read data to master.
hresp  output  1  muxed response to master.
hready  output  1  bus hready to master and all slaves.
hsel_dp  output  slave_c  registered data-phase select (visibility/debug).
def_err  output  1  high while the default slave drives ERROR.

Behaviour:
- Reset: when hreset=1 at a rising edge, hsel_dp=0 and the default-slave FSM goes to DEF_IDLE. Outputs next cycle: hready=1, hresp=0, hrdata=0, def_err=0. Reset overrides any pending stall or ERROR sequence mid-transfer.
- Address-phase capture happens only at edges where hready=1:
  - hsel_dp <= hsel.
  - The default slave is triggered when hsel==0 and htrans[1]==1.
  - When hready=0, hsel_dp and the FSM hold.
- Multi-hot hsel (overlapping map): the lowest set index wins for muxing. hsel_dp stores the raw value.
- Data-phase mux is combinational from hsel_dp, so it adds zero cycles of latency:
  - Slave i selected: hrdata=hrdata_s[i], hresp=hresp_s[i], hready=hreadyout_s[i].
  - hsel_dp==0 and FSM in DEF_IDLE (IDLE/BUSY to an unmapped address, or bus idle): hrdata=0, hresp=OKAY, hready=1.
- Default-slave FSM states: DEF_IDLE, DEF_ERR1, DEF_ERR2.
  - DEF_IDLE -> DEF_ERR1 on trigger.
  - DEF_ERR1 drives hready=0, hresp=1, hrdata=0; always -> DEF_ERR2 on the next edge.
  - DEF_ERR2 drives hready=1, hresp=1, hrdata=0. It goes -> DEF_ERR1 if a new trigger is sampled at that edge (back-to-back unmapped), otherwise -> DEF_IDLE.
  - def_err=1 in DEF_ERR1 and DEF_ERR2.
- A mapped address sampled during DEF_ERR2 loads hsel_dp normally; the slave owns the next data phase.
- A slave stall (hreadyout_s[i]=0) holds hsel_dp, so the stalled slave keeps ownership until it completes.
- Slave ERROR responses pass through unchanged; the block does not sequence them.

Decomposition:
- Shared package (ahb_pkg, with SLAVE_COUNT from system settings):
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ localparams.
  - HRESP_OKAY/ERROR localparams.
  - def_state_t enum {DEF_IDLE, DEF_ERR1, DEF_ERR2}.
- Sub-module ahb_def_slave: FSM plus trigger logic, outputting def_hready, def_hresp, def_err.
- ahb_resp_mux: capture register, priority mux, and the final merge with ahb_def_slave.

Test Plan (slave_c=3):
1. Reset held 3 cycles, then released -> hready=1, hresp=0, hrdata=0, hsel_dp=0, def_err=0.
2. hsel=3'b010, htrans=NONSEQ, hready=1; next cycle hrdata_s[1]=32'hDEADBEEF, hreadyout_s[1]=1 -> hsel_dp=3'b010, hrdata=32'hDEADBEEF, hready=1.
3. Slave 2 selected; hreadyout_s[2]=0 for 2 cycles, with hsel=3'b001 driven meanwhile -> hready=0 for 2 cycles, hsel_dp stays 3'b100 until hreadyout_s[2]=1, then captures 3'b001.
4. hsel=0, htrans=NONSEQ -> cycle1 hready=0/hresp=1; cycle2 hready=1/hresp=1; cycle3 hresp=0, def_err=0.
5. Back-to-back unmapped NONSEQ then SEQ (second sampled in DEF_ERR2) -> sequence ERR1, ERR2, ERR1, ERR2; hready pattern 0,1,0,1.
6. Assert hreset during DEF_ERR1 -> next cycle DEF_IDLE, hready=1, hresp=0; hsel=0 with htrans=IDLE -> hready=1, hresp=OKAY, no ERROR.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer/response encodings and default-slave state type
package ahb_pkg;
    localparam int SLAVE_COUNT = 3;
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [1:0] {DEF_IDLE, DEF_ERR1, DEF_ERR2} def_state_t;
endpackage

// File: rtl/ahb_resp_mux_if.sv
// ahb_resp_mux_if: decoder/slave response bundle seen by the response multiplexer
interface ahb_resp_mux_if #(parameter int slave_c = ahb_pkg::SLAVE_COUNT);
    logic [slave_c-1:0]       hsel;
    logic [1:0]               htrans;
    logic [slave_c-1:0][31:0] hrdata_s;
    logic [slave_c-1:0]       hresp_s;
    logic [slave_c-1:0]       hreadyout_s;
    logic [31:0]              hrdata;
    logic                     hresp;
    logic                     hready;
    logic [slave_c-1:0]       hsel_dp;
    logic                     def_err;
    modport slave (input hsel, htrans, hrdata_s, hresp_s, hreadyout_s,
                   output hrdata, hresp, hready, hsel_dp, def_err);
    modport master (output hsel, htrans, hrdata_s, hresp_s, hreadyout_s,
                    input hrdata, hresp, hready, hsel_dp, def_err);
endinterface

// File: rtl/ahb_def_slave.sv
// ahb_def_slave: two-cycle ERROR responder for active transfers to unmapped space
module ahb_def_slave
    import ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hready,
    input  logic       hsel_hit,
    input  logic [1:0] htrans,
    output logic       def_hready,
    output logic       def_hresp,
    output logic       def_err
);
    def_state_t state, state_nx;
    logic trig;
    always_ff @(posedge hclk) begin
        if (hreset) state <= DEF_IDLE;
        else state <= state_nx;
    end
    // ERR1 always advances: it is the stall cycle the bus is waiting on
    always_comb begin
        trig = !hsel_hit && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
        state_nx = state == DEF_ERR1 ? DEF_ERR2 :
                   !hready ? state :
                   trig ? DEF_ERR1 : DEF_IDLE;
        def_hready = state != DEF_ERR1;
        def_hresp = state != DEF_IDLE ? HRESP_ERROR : HRESP_OKAY;
        def_err = state != DEF_IDLE;
    end
endmodule

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: data-phase select register, priority response mux and default-slave merge
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int slave_c = SLAVE_COUNT
) (
    input logic hclk,
    input logic hreset,
    ahb_resp_mux_if.slave bus
);
    logic [slave_c-1:0] hsel_dp;
    logic [31:0] sel_rdata;
    logic sel_resp, sel_ready, hit, def_hready, def_hresp;
    always_ff @(posedge hclk) begin
        if (hreset) hsel_dp <= '0;
        else if (bus.hready) hsel_dp <= bus.hsel;
    end
    ahb_def_slave u_def (
        .hclk(hclk),
        .hreset(hreset),
        .hready(bus.hready),
        .hsel_hit(|bus.hsel),
        .htrans(bus.htrans),
        .def_hready(def_hready),
        .def_hresp(def_hresp),
        .def_err(bus.def_err)
    );
    // Scan high to low so the lowest set index ends up owning the bus
    always_comb begin
        sel_rdata = '0;
        sel_resp = HRESP_OKAY;
        sel_ready = 1'b1;
        hit = 1'b0;
        for (int i = slave_c - 1; i >= 0; i--) begin
            if (hsel_dp[i]) begin
                sel_rdata = bus.hrdata_s[i];
                sel_resp = bus.hresp_s[i];
                sel_ready = bus.hreadyout_s[i];
                hit = 1'b1;
            end
        end
        bus.hrdata = hit ? sel_rdata : 32'h0;
        bus.hresp = hit ? sel_resp : def_hresp;
        bus.hready = hit ? sel_ready : def_hready;
        bus.hsel_dp = hsel_dp;
    end
endmodule
